// File: rtl/motors_ctrl_nd.sv
// N-axis stepper/servo motion controller: queued commands, pen servo sequencing,
// and DDA-interpolated simultaneous stepping so every axis finishes together.

module motors_ctrl_nd_axis #(
  parameter int CNT_BITS     = 12,
  parameter int PULSE_FACTOR = 4,
  parameter int SCALED_BITS  = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CNT_BITS-1:0]    pulses,
  input  logic                   load,
  input  logic                   step_set,
  input  logic                   step_clr,
  input  logic [SCALED_BITS-1:0] m_val,
  output logic [SCALED_BITS-1:0] mag_c,
  output logic [SCALED_BITS-1:0] mag,
  output logic                   step,
  output logic                   dir
);
  logic [CNT_BITS-1:0]    abs_p;
  logic [SCALED_BITS-1:0] acc, acc_src, mag_src;
  logic [SCALED_BITS:0]   sum;

  // Unsigned view of the negated value keeps -2^(CNT_BITS-1) exact.
  assign abs_p   = pulses[CNT_BITS-1] ? (~pulses + CNT_BITS'(1)) : pulses;
  assign mag_c   = SCALED_BITS'(abs_p) * SCALED_BITS'(PULSE_FACTOR);
  assign acc_src = load ? '0 : acc;
  assign mag_src = load ? mag_c : mag;
  assign sum     = {1'b0, acc_src} + {1'b0, mag_src};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag  <= '0;
      acc  <= '0;
      step <= 1'b0;
      dir  <= 1'b0;
    end else begin
      if (load) begin
        mag <= mag_c;
        dir <= pulses[CNT_BITS-1];
        acc <= '0;
      end
      if (step_set) begin
        if (sum >= {1'b0, m_val}) begin
          step <= 1'b1;
          acc  <= SCALED_BITS'(sum - {1'b0, m_val});
        end else begin
          step <= 1'b0;
          acc  <= sum[SCALED_BITS-1:0];
        end
      end else if (step_clr) begin
        step <= 1'b0;
      end
    end
  end
endmodule

module motors_ctrl_nd #(
  parameter int NUM_AXES         = 2,
  parameter int CNT_BITS         = 12,
  parameter int PULSE_FACTOR     = 4,
  parameter int FIFO_DEPTH       = 4,
  parameter int PULSE_WIDTH      = 10,
  parameter int SERVO_PERIOD     = 2000,
  parameter int SERVO_UP_WIDTH   = 100,
  parameter int SERVO_DOWN_WIDTH = 200,
  parameter int SERVO_SETTLE     = 25
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_pen_down,
  input  logic [NUM_AXES*CNT_BITS-1:0] cmd_pulses,
  input  logic                         abort,
  output logic                         busy,
  output logic                         cmd_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [NUM_AXES-1:0]          out_step,
  output logic [NUM_AXES-1:0]          dir,
  output logic [NUM_AXES-1:0]          n_en,
  output logic                         out_servo
);
  localparam int SCALED_BITS = CNT_BITS - 1 + $clog2(PULSE_FACTOR + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int PWMW = $clog2(SERVO_PERIOD + 1);
  localparam int STW  = $clog2(SERVO_SETTLE + 1);
  localparam int TW   = $clog2(PULSE_WIDTH + 1);

  typedef struct packed {
    logic                         pen;
    logic [NUM_AXES*CNT_BITS-1:0] pulses;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, LOAD, SERVO_WAIT, STEP_HI, STEP_LO, DONE} state_t;

  state_t state, state_n;
  cmd_t   mem [FIFO_DEPTH];
  cmd_t   cur;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   count;
  logic            push, pop, pen, out_servo_r;
  logic [STW-1:0]  settle;
  logic [TW-1:0]   tick;
  logic [PWMW-1:0] pwm_cnt, cur_width;
  logic [SCALED_BITS-1:0] rem, m_q, m_c, m_src;
  logic [NUM_AXES-1:0][SCALED_BITS-1:0] mag_c, mag;
  logic wrap, tick_end, load, step_set, step_clr, stepping;

  assign cmd_ready  = count < LW'(FIFO_DEPTH);
  assign push       = cmd_valid && cmd_ready && !abort;
  assign pop        = (state == IDLE) && (count != '0) && !abort;
  assign fifo_level = count;
  assign busy       = (state != IDLE) || (count != '0);
  assign cmd_done   = (state == DONE) && !abort;
  assign out_servo  = out_servo_r;

  assign wrap     = clk_en && (pwm_cnt == PWMW'(SERVO_PERIOD - 1));
  assign tick_end = clk_en && (tick == TW'(PULSE_WIDTH - 1));
  assign stepping = (state == STEP_HI) || (state == STEP_LO);
  assign load     = (state == LOAD);
  assign step_set = (state_n == STEP_HI) && (state != STEP_HI);
  assign step_clr = (state == STEP_HI) && (state_n != STEP_HI);
  assign m_src    = load ? m_c : m_q;

  always_comb begin
    m_c = '0;
    for (int i = 0; i < NUM_AXES; i++)
      if (mag_c[i] > m_c) m_c = mag_c[i];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (count != '0) state_n = LOAD;
      LOAD:       if (cur.pen != pen)  state_n = SERVO_WAIT;
                  else if (m_c == '0)  state_n = DONE;
                  else                 state_n = STEP_HI;
      SERVO_WAIT: if (wrap && settle == STW'(SERVO_SETTLE - 1))
                    state_n = (m_q == '0) ? DONE : STEP_HI;
      STEP_HI:    if (tick_end) state_n = STEP_LO;
      STEP_LO:    if (tick_end) state_n = (rem == SCALED_BITS'(1)) ? DONE : STEP_HI;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_pen_down, cmd_pulses};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cur         <= '0;
      pen         <= 1'b0;
      settle      <= '0;
      tick        <= '0;
      rem         <= '0;
      m_q         <= '0;
      pwm_cnt     <= '0;
      cur_width   <= PWMW'(SERVO_UP_WIDTH);
      out_servo_r <= 1'b0;
    end else begin
      // PWM free-runs; the width for a new pen state is picked up only at a wrap.
      if (clk_en) begin
        if (wrap) begin
          pwm_cnt   <= '0;
          cur_width <= pen ? PWMW'(SERVO_DOWN_WIDTH) : PWMW'(SERVO_UP_WIDTH);
        end else begin
          pwm_cnt <= pwm_cnt + PWMW'(1);
        end
        out_servo_r <= pwm_cnt < cur_width;
      end

      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        tick   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          cur    <= mem[rd_ptr];
        end
        count <= count + LW'(push) - LW'(pop);

        case (state)
          LOAD: begin
            rem    <= m_c;
            m_q    <= m_c;
            settle <= '0;
            tick   <= '0;
            pen    <= cur.pen;
          end
          SERVO_WAIT: if (wrap) settle <= settle + STW'(1);
          STEP_HI, STEP_LO: begin
            if (clk_en) tick <= tick_end ? '0 : tick + TW'(1);
            if (state == STEP_LO && tick_end) rem <= rem - SCALED_BITS'(1);
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
    motors_ctrl_nd_axis #(
      .CNT_BITS    (CNT_BITS),
      .PULSE_FACTOR(PULSE_FACTOR),
      .SCALED_BITS (SCALED_BITS)
    ) u_axis (
      .clk     (clk),
      .reset   (reset),
      .pulses  (cur.pulses[g*CNT_BITS +: CNT_BITS]),
      .load    (load),
      .step_set(step_set),
      .step_clr(step_clr),
      .m_val   (m_src),
      .mag_c   (mag_c[g]),
      .mag     (mag[g]),
      .step    (out_step[g]),
      .dir     (dir[g])
    );
    assign n_en[g] = !(stepping && (mag[g] != '0));
  end
endmodule

// File: tb/tb_motors_ctrl_nd.sv
// Scoreboard bench for motors_ctrl_nd: stimulus queues expected per-command results,
// a negedge monitor counts step pulses and checks them on each cmd_done.

module tb_motors_ctrl_nd;
  localparam int NA = 2, CB = 6, PF = 4, FD = 4, PW = 10;
  localparam int SP = 200, SU = 10, SD = 20, SS = 5;
  localparam int LW = $clog2(FD) + 1;

  logic clk = 0, reset = 1, clk_en = 0, cmd_valid = 0, cmd_pen_down = 0, abort = 0;
  logic [NA*CB-1:0] cmd_pulses = '0;
  logic cmd_ready, busy, cmd_done, out_servo;
  logic [LW-1:0] fifo_level;
  logic [NA-1:0] out_step, dir, n_en;

  motors_ctrl_nd #(
    .NUM_AXES(NA), .CNT_BITS(CB), .PULSE_FACTOR(PF), .FIFO_DEPTH(FD),
    .PULSE_WIDTH(PW), .SERVO_PERIOD(SP), .SERVO_UP_WIDTH(SU),
    .SERVO_DOWN_WIDTH(SD), .SERVO_SETTLE(SS)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_pen_down(cmd_pen_down), .cmd_pulses(cmd_pulses),
    .abort(abort), .busy(busy), .cmd_done(cmd_done), .fifo_level(fifo_level),
    .out_step(out_step), .dir(dir), .n_en(n_en), .out_servo(out_servo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xs; int ys; int dir; int hw; int lat_lo; int lat_hi; int en; int push_cyc;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  int n_pass = 0, n_total = 0;
  int en_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;
  // en_mode 1: clk_en high at edges whose cyc index is a multiple of 4
  always @(negedge clk) clk_en <= (en_mode == 0) || ((cyc + 1) % 4 == 0);

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // Monitor
  int cnt_x = 0, cnt_y = 0, run = 0, hmin = 1000000, hmax = 0, encyc = 0;
  logic [NA-1:0] prev = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      cnt_x = 0; cnt_y = 0; run = 0; hmin = 1000000; hmax = 0; encyc = 0; prev = '0;
    end else begin
      if (out_step[0] && !prev[0]) cnt_x++;
      if (out_step[1] && !prev[1]) cnt_y++;
      if (out_step[0]) run++;
      else if (prev[0]) begin
        if (run < hmin) hmin = run;
        if (run > hmax) hmax = run;
        run = 0;
      end
      if (n_en != 2'b11) encyc++;
      if (cmd_done) begin
        check("done_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("x_pulses", cnt_x, e.xs);
          check("y_pulses", cnt_y, e.ys);
          check("dir", int'(dir), e.dir);
          if (e.hw >= 0) begin
            check("x_high_min", hmin, e.hw);
            check("x_high_max", hmax, e.hw);
          end
          if (e.lat_lo >= 0) check_rng("done_latency", cyc - e.push_cyc, e.lat_lo, e.lat_hi);
          if (e.en >= 0) check("n_en_low_cycles", encyc, e.en);
        end
        cnt_x = 0; cnt_y = 0; run = 0; hmin = 1000000; hmax = 0; encyc = 0;
      end else if (!busy) begin
        cnt_x = 0; cnt_y = 0; run = 0; hmin = 1000000; hmax = 0; encyc = 0;
      end
      prev = out_step;
    end
  end

  task automatic push_cmd(input logic pen, input int x, input int y, input int xs,
                          input int ys, input int d, input int hw, input int lo,
                          input int hi, input int en, input bit align);
    exp_t e;
    int t = 0;
    while ((!cmd_ready || (align && ((cyc + 3) % 4 != 0))) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", int'(cmd_ready), 1);
    cmd_pen_down = pen;
    cmd_pulses   = {CB'(y), CB'(x)};
    cmd_valid    = 1;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    e.xs = xs; e.ys = ys; e.dir = d; e.hw = hw; e.lat_lo = lo; e.lat_hi = hi;
    e.en = en; e.push_cyc = cyc;
    q.push_back(e);
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while ((q.size() != 0 || busy) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", q.size(), 0);
  endtask

  task automatic servo_high(output int w);
    int t = 0;
    while (out_servo && t < 2000) begin @(negedge clk); t++; end
    while (!out_servo && t < 2000) begin @(negedge clk); t++; end
    w = 0;
    while (out_servo && w < 2000) begin @(negedge clk); w++; end
  endtask

  initial begin
    int w, t;
    repeat (3) @(negedge clk);
    check("rst_out_step", int'(out_step), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_n_en", int'(n_en), 3);
    check("rst_out_servo", int'(out_servo), 0);
    check("rst_cmd_done", int'(cmd_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fifo_level", int'(fifo_level), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    reset = 0;

    servo_high(w);
    check("servo_up_width", w, SU);

    // pen up, (+3,-1): x 12 pulses, y 4, major axis 12 periods of 20 clk
    push_cmd(0, 3, -1, 12, 4, 2, PW, 242, 242, 240, 0);
    wait_drain(2000);

    // pen down, no motion: only the servo settle time
    push_cmd(1, 0, 0, 0, 0, 0, -1, (SS-1)*SP+3, SS*SP+2, 0, 0);
    wait_drain(5000);
    servo_high(w);
    check("servo_down_width", w, SD);

    // queue fill: first pops at once, next four fill the FIFO
    push_cmd(1, 1, 0, 4, 0, 0, PW, -1, -1, -1, 0);
    push_cmd(1, 0, 1, 0, 4, 0, -1, -1, -1, -1, 0);
    push_cmd(1, 2, 1, 8, 4, 0, PW, -1, -1, -1, 0);
    push_cmd(1, 1, 2, 4, 8, 0, PW, -1, -1, -1, 0);
    push_cmd(1, -1, 1, 4, 4, 1, PW, -1, -1, -1, 0);
    check("full_level", int'(fifo_level), 4);
    check("full_ready", int'(cmd_ready), 0);
    push_cmd(1, 3, 0, 12, 0, 0, PW, -1, -1, -1, 0);
    wait_drain(3000);

    // abort while stepping with two queued
    push_cmd(1, 3, 3, 12, 12, 0, PW, -1, -1, -1, 0);
    push_cmd(1, 1, 1, 4, 4, 0, PW, -1, -1, -1, 0);
    push_cmd(1, 2, 2, 8, 8, 0, PW, -1, -1, -1, 0);
    t = 0;
    while (!out_step[0] && t < 100) begin @(negedge clk); t++; end
    check("abort_pre_step", int'(out_step[0]), 1);
    abort = 1;
    @(posedge clk);
    #1;
    abort = 0;
    q.delete();
    check("abort_out_step", int'(out_step), 0);
    check("abort_n_en", int'(n_en), 3);
    check("abort_fifo_level", int'(fifo_level), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_cmd_ready", int'(cmd_ready), 1);
    repeat (200) @(negedge clk);

    // most-negative request with clk_en every 4th clk
    en_mode = 1;
    repeat (8) @(negedge clk);
    push_cmd(1, -32, 0, 128, 0, 1, 4*PW, -1, -1, -1, 1);
    wait_drain(20000);
    en_mode = 0;
    repeat (4) @(negedge clk);

    // asynchronous reset mid-pulse
    push_cmd(1, 3, 0, 12, 0, 0, PW, -1, -1, -1, 0);
    t = 0;
    while (!out_step[0] && t < 100) begin @(negedge clk); t++; end
    check("arst_pre_step", int'(out_step[0]), 1);
    #2 reset = 1;
    #1;
    q.delete();
    check("arst_out_step", int'(out_step), 0);
    check("arst_out_servo", int'(out_servo), 0);
    check("arst_n_en", int'(n_en), 3);
    check("arst_busy", int'(busy), 0);
    check("arst_fifo_level", int'(fifo_level), 0);
    @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end
endmodule
